// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing FSM for a small multicycle core. It fetches an instruction,
// executes it in one or two cycles, and runs a data-memory handshake for
// loads and stores. It also counts retired instructions.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   inst_valid        fetched instruction present (looked at in FETCH only)
//   fetch_req         request instruction at current PC (registered)
//   ir_load           latch fetched instruction into decoder (combinational)
//   ctrl_lsu[3:0]     [1:0] width 00 none/01 word/10 half/11 byte,
//                     [2] unsigned load, [3] store (sampled in EXEC)
//   ctrl_multicycle   ALU op needs an extra execute cycle (sampled in EXEC)
//   addr_lo[1:0]      effective address low bits (sampled in EXEC)
//   mem_req, mem_we   data-memory request / write enable (registered)
//   mem_ack           data-memory acknowledge (looked at in MEM only)
//   pc_en, rf_we      retire strobes (combinational)
//   trap, trap_clear  misalignment trap flag (registered) and its clear
//   instret[31:0]     retired-instruction counter, wraps modulo 2^32
//
// Build option
//   MISALIGN_TRAP_EN  when defined, a misaligned word or half access traps
//                     instead of going to memory. When undefined, trap is
//                     always 0 and addr_lo and trap_clear have no effect.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        fetch_req,
  output logic        ir_load,
  input  logic [3:0]  ctrl_lsu,
  input  logic        ctrl_multicycle,
  input  logic [1:0]  addr_lo,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        rf_we,
  output logic        trap,
  input  logic        trap_clear,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    EXEC2 = 3'd3,
    MEM   = 3'd4,
    TRAP  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next;
  logic [31:0] instret_r;

  // A word access must be 4-byte aligned. A half access must be 2-byte aligned.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr);
    logic bad;
    case (width)
      2'b01:   bad = (addr != 2'b00);
      2'b10:   bad = addr[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

`ifdef MISALIGN_TRAP_EN
  // The unsigned-load flag only matters to the load aligner, not to sequencing.
  logic unused_inputs_s;
  assign unused_inputs_s = ctrl_lsu[2];
`else
  // Without the trap, alignment and trap clearing play no part in sequencing.
  logic unused_inputs_s;
  assign unused_inputs_s = ^{ctrl_lsu[2], addr_lo, trap_clear, misaligned(2'b00, 2'b00)};
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state decode and the handshake-dependent strobes.
  always_comb begin
    state_next = state_r;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    rf_we      = 1'b0;
    case (state_r)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (inst_valid) begin
          ir_load    = 1'b1;
          state_next = EXEC;
        end else begin
          state_next = FETCH;
        end
      end
      EXEC: begin
        if (ctrl_lsu[1:0] == 2'b00) begin
          if (ctrl_multicycle) begin
            state_next = EXEC2;
          end else begin
            pc_en      = 1'b1;
            rf_we      = 1'b1;
            state_next = FETCH;
          end
        end else begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned(ctrl_lsu[1:0], addr_lo)) begin
            state_next = TRAP;
          end else begin
            state_next = MEM;
          end
`else
          state_next = MEM;
`endif
        end
      end
      EXEC2: begin
        pc_en      = 1'b1;
        rf_we      = 1'b1;
        state_next = FETCH;
      end
      MEM: begin
        if (mem_ack) begin
          // mem_we holds the direction captured in EXEC. Stores do not write the regfile.
          pc_en      = 1'b1;
          rf_we      = ~mem_we;
          state_next = FETCH;
        end else begin
          state_next = MEM;
        end
      end
      TRAP: begin
`ifdef MISALIGN_TRAP_EN
        if (trap_clear) begin
          state_next = FETCH;
        end else begin
          state_next = TRAP;
        end
`else
        state_next = FETCH;
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs are registered from the next state, so each one lines up
  // with the state it decodes. mem_we captures the store bit on entry to MEM
  // and holds it until the access completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_req <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      trap      <= 1'b0;
    end else begin
      fetch_req <= (state_next == FETCH);
      mem_req   <= (state_next == MEM);
      if (state_next == MEM) begin
        mem_we <= (state_r == EXEC) ? ctrl_lsu[3] : mem_we;
      end else begin
        mem_we <= 1'b0;
      end
`ifdef MISALIGN_TRAP_EN
      trap <= (state_next == TRAP);
`else
      trap <= 1'b0;
`endif
    end
  end

  // Retired-instruction counter. It wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_r <= 32'd0;
    end else if (pc_en) begin
      instret_r <= instret_r + 32'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

  assign instret = instret_r;

endmodule
